// File: rtl/writeback_stage_pkg.sv
// ============================================================================
// writeback_stage_pkg : shared constants and types for the writeback stage
// Rev 1.0
// ============================================================================
`default_nettype none

package writeback_stage_pkg;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  localparam int DATA_W_DEF   = 16;
  localparam int REGSEL_W_DEF = 3;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [0:0] {
    WB_RUN    = 1'b0,
    WB_HALTED = 1'b1
  } wb_state_e;

endpackage : writeback_stage_pkg

`default_nettype wire

// File: rtl/writeback_stage_if.sv
// ============================================================================
// writeback_stage_if : M/W inputs and register-file / status outputs
// Rev 1.0
// ============================================================================
`default_nettype none

interface writeback_stage_if #(
  parameter int DATA_W   = 16,
  parameter int REGSEL_W = 3,
  parameter int CNT_W    = 16
);

  logic                valid_mw;
  logic                halt_mw;
  logic [DATA_W-1:0]   aluresult_mw;
  logic [DATA_W-1:0]   memreaddata_mw;
  logic                regwrite_mw;
  logic [REGSEL_W-1:0] writeregsel_mw;
  logic                writedatasel_mw;
  logic                stall_w;

  logic                regwrite_wd;
  logic [REGSEL_W-1:0] writeregsel_wd;
  logic [DATA_W-1:0]   writedata_wd;
  logic                halted;
  logic [CNT_W-1:0]    retired_count;

  // Driver side: the memory stage and hazard logic.
  modport master (
    output valid_mw, halt_mw, aluresult_mw, memreaddata_mw, regwrite_mw,
           writeregsel_mw, writedatasel_mw, stall_w,
    input  regwrite_wd, writeregsel_wd, writedata_wd, halted, retired_count
  );

  // Writeback stage side.
  modport slave (
    input  valid_mw, halt_mw, aluresult_mw, memreaddata_mw, regwrite_mw,
           writeregsel_mw, writedatasel_mw, stall_w,
    output regwrite_wd, writeregsel_wd, writedata_wd, halted, retired_count
  );

endinterface : writeback_stage_if

`default_nettype wire

// File: rtl/writeback_stage_mw_pipe_reg.sv
// ============================================================================
// mw_pipe_reg : width-parameterised pipeline register with sync reset/enable
// Rev 1.0
// ============================================================================
`default_nettype none

module mw_pipe_reg #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_en,
  input  wire logic [W-1:0] i_d,
  output logic      [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : mw_pipe_reg

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// writeback_stage : M/W register, write-data select, halt FSM, retire counter
// Rev 1.0
// ============================================================================
`default_nettype none

module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REGSEL_W = REGSEL_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input wire logic          clk,
  input wire logic          rst,
  writeback_stage_if.slave  wb
);

  localparam int MW_W = 2 * DATA_W + REGSEL_W + 4;

  wb_state_e           r_state;
  wb_state_e           w_state_next;
  logic [CNT_W-1:0]    r_count;
  logic [MW_W-1:0]     w_mw_d;
  logic [MW_W-1:0]     r_mw_q;
  logic                w_load;

  logic                w_valid_w;
  logic                w_halt_w;
  logic [DATA_W-1:0]   w_aluresult_w;
  logic [DATA_W-1:0]   w_memdata_w;
  logic                w_regwrite_w;
  logic [REGSEL_W-1:0] w_writeregsel_w;
  logic                w_writedatasel_w;

  // Once HALT retires the register is frozen until reset.
  assign w_load = ~wb.stall_w & (r_state == WB_RUN);

  assign w_mw_d = {wb.valid_mw, wb.halt_mw, wb.aluresult_mw, wb.memreaddata_mw,
                   wb.regwrite_mw, wb.writeregsel_mw, wb.writedatasel_mw};

  mw_pipe_reg #(
    .W (MW_W)
  ) u_mw_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_load),
    .i_d  (w_mw_d),
    .o_q  (r_mw_q)
  );

  assign {w_valid_w, w_halt_w, w_aluresult_w, w_memdata_w,
          w_regwrite_w, w_writeregsel_w, w_writedatasel_w} = r_mw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WB_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WB_RUN: begin
        if (w_load && wb.valid_mw && wb.halt_mw) begin
          w_state_next = WB_HALTED;
        end
      end
      WB_HALTED: w_state_next = WB_HALTED;
      default:   w_state_next = WB_RUN;
    endcase
  end

  // HALT counts as retired; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_load && wb.valid_mw && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign wb.regwrite_wd    = w_valid_w & w_regwrite_w & ~w_halt_w;
  assign wb.writeregsel_wd = w_writeregsel_w;
  assign wb.writedata_wd   = (w_writedatasel_w == WB_SEL_MEM) ? w_memdata_w
                                                              : w_aluresult_w;
  assign wb.halted         = (r_state == WB_HALTED);
  assign wb.retired_count  = r_count;

endmodule : writeback_stage

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// tb_writeback_stage : directed scoreboard bench for writeback_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_writeback_stage;

  logic clk;
  logic rst;

  writeback_stage_if #(.DATA_W(16), .REGSEL_W(3), .CNT_W(16)) bus ();

  writeback_stage #(
    .DATA_W   (16),
    .REGSEL_W (3),
    .CNT_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [2:0]  sel;
    logic [15:0] data;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks;
  int n_errors;

  // Reference model state (M/W register, FSM, counter).
  logic        m_valid, m_halt, m_rw, m_ds, m_halted;
  logic [15:0] m_alu, m_mem, m_cnt;
  logic [2:0]  m_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic stall, input logic v, input logic h,
                      input logic rw, input logic [2:0] sel, input logic ds,
                      input logic [15:0] alu, input logic [15:0] mem);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst                 = r;
    bus.stall_w         = stall;
    bus.valid_mw        = v;
    bus.halt_mw         = h;
    bus.regwrite_mw     = rw;
    bus.writeregsel_mw  = sel;
    bus.writedatasel_mw = ds;
    bus.aluresult_mw    = alu;
    bus.memreaddata_mw  = mem;
    if (r) begin
      {m_valid, m_halt, m_rw, m_ds, m_halted} = '0;
      m_alu = '0; m_mem = '0; m_cnt = '0; m_sel = '0;
    end else if (!m_halted && !stall) begin
      m_valid = v; m_halt = h; m_rw = rw; m_sel = sel; m_ds = ds;
      m_alu = alu; m_mem = mem;
      if (v && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (v && h) m_halted = 1'b1;
    end
    e.rw     = m_valid & m_rw & ~m_halt;
    e.sel    = m_sel;
    e.data   = m_ds ? m_mem : m_alu;
    e.halted = m_halted;
    e.cnt    = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("regwrite_wd",    32'(bus.regwrite_wd),    32'(got.rw));
    chk("writeregsel_wd", 32'(bus.writeregsel_wd), 32'(got.sel));
    chk("writedata_wd",   32'(bus.writedata_wd),   32'(got.data));
    chk("halted",         32'(bus.halted),         32'(got.halted));
    chk("retired_count",  32'(bus.retired_count),  32'(got.cnt));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    {m_valid, m_halt, m_rw, m_ds, m_halted} = '0;
    m_alu = '0; m_mem = '0; m_cnt = '0; m_sel = '0;
    rst = 1'b1;
    bus.stall_w = 1'b0; bus.valid_mw = 1'b0; bus.halt_mw = 1'b0;
    bus.regwrite_mw = 1'b0; bus.writeregsel_mw = '0; bus.writedatasel_mw = 1'b0;
    bus.aluresult_mw = '0; bus.memreaddata_mw = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 3'd0, 0, 16'h0000, 16'h0000);
    step(1, 0, 1, 0, 1, 3'd7, 1, 16'hFFFF, 16'hFFFF);
    chk("reset_all_zero",
        32'({bus.regwrite_wd, bus.writeregsel_wd, bus.writedata_wd, bus.halted, bus.retired_count}), 32'd0);

    // ALU write, then load write
    step(0, 0, 1, 0, 1, 3'd3, 0, 16'h1234, 16'hBEEF);
    chk("alu_data_literal", 32'(bus.writedata_wd), 32'h1234);
    step(0, 0, 1, 0, 1, 3'd3, 1, 16'h1234, 16'hBEEF);
    chk("mem_data_literal", 32'(bus.writedata_wd), 32'hBEEF);

    // Bubble, then valid instruction held by a 3-cycle stall with changing inputs
    step(0, 0, 0, 0, 1, 3'd6, 0, 16'h5555, 16'h6666);
    step(0, 0, 1, 0, 1, 3'd5, 0, 16'h1111, 16'h2222);
    step(0, 1, 1, 0, 1, 3'd1, 1, 16'hAAAA, 16'hBBBB);
    step(0, 1, 1, 0, 0, 3'd2, 0, 16'hCCCC, 16'hDDDD);
    step(0, 1, 0, 0, 1, 3'd4, 1, 16'hEEEE, 16'hFFFF);
    chk("stall_count_literal", 32'(bus.retired_count), 32'd3);
    step(0, 0, 1, 0, 0, 3'd2, 1, 16'h0F0F, 16'hF0F0);

    // Valid HALT that also requests a write, then ignored instructions
    step(0, 0, 1, 1, 1, 3'd7, 0, 16'h7777, 16'h8888);
    step(0, 0, 1, 0, 1, 3'd1, 0, 16'h0101, 16'h0202);
    step(0, 0, 1, 0, 1, 3'd2, 1, 16'h0303, 16'h0404);
    step(0, 1, 1, 1, 1, 3'd3, 0, 16'h0505, 16'h0606);
    step(1, 1, 1, 0, 1, 3'd4, 1, 16'h0707, 16'h0808);

    // HALT arriving under a 2-cycle stall
    step(0, 0, 1, 0, 1, 3'd2, 0, 16'h4242, 16'h0000);
    step(0, 1, 1, 1, 0, 3'd0, 0, 16'h0000, 16'h0000);
    step(0, 1, 1, 1, 0, 3'd0, 0, 16'h0000, 16'h0000);
    step(0, 0, 1, 1, 0, 3'd0, 0, 16'h0000, 16'h0000);
    step(0, 0, 1, 0, 1, 3'd5, 0, 16'h9999, 16'h0000);
    step(1, 0, 0, 0, 0, 3'd0, 0, 16'h0000, 16'h0000);

    // Counter saturation
    for (int i = 0; i < 65534; i++) begin
      step(0, 0, 1, 0, 1, 3'(i), i[0], 16'(i), 16'(~i));
    end
    chk("cnt_fffe_literal", 32'(bus.retired_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 1, 3'd6, 0, 16'hABCD, 16'h0000);
    end
    chk("cnt_sat_literal", 32'(bus.retired_count), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_writeback_stage

`default_nettype wire
